// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/IR owner with req/ack instruction fetch; optional FETCH_TIMEOUT_EN abort
module fetch_unit #(
    parameter int                ADDR_W         = 16,
    parameter int                INSTR_W        = 19,
    parameter int                OPC_W          = 5,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int                TIMEOUT_CYCLES = 64
) (
    input  logic                     CLK,
    input  logic                     EN,
    input  logic                     LOAD_IR,
    input  logic                     LOAD_PC,
    input  logic                     INC_PC,
    input  logic [ADDR_W-1:0]        BR_ADDR,
    output logic                     IM_REQ,
    output logic [ADDR_W-1:0]        IM_ADDR,
    input  logic                     IM_ACK,
    input  logic [INSTR_W-1:0]       IM_RDATA,
    output logic [OPC_W-1:0]         OPCODE,
    output logic [INSTR_W-OPC_W-1:0] OPERANDS,
    output logic [ADDR_W-1:0]        PC,
    output logic                     IR_VALID,
    output logic                     BUSY,
    output logic                     FETCH_ERR
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state;
    logic [INSTR_W-1:0] ir;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wait_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign FETCH_ERR          = 1'b0;
`endif

    // Opcode and operand fields are plain slices of the instruction register
    assign OPCODE   = ir[INSTR_W-1 -: OPC_W];
    assign OPERANDS = ir[INSTR_W-OPC_W-1:0];

    // PC update runs every cycle regardless of FSM state; fetch FSM latches the old PC
    always_ff @(posedge CLK) begin
        if (!EN) begin
            state    <= S_IDLE;
            PC       <= RESET_PC;
            ir       <= '0;
            IR_VALID <= 1'b0;
            IM_REQ   <= 1'b0;
            IM_ADDR  <= '0;
            BUSY     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt  <= '0;
            FETCH_ERR <= 1'b0;
`endif
        end else begin
            if (LOAD_PC) begin
                PC <= BR_ADDR;
            end else if (INC_PC) begin
                PC <= PC + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (LOAD_IR) begin
                        IM_ADDR  <= PC;
                        IM_REQ   <= 1'b1;
                        BUSY     <= 1'b1;
                        IR_VALID <= 1'b0;
                        state    <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (IM_ACK) begin
                        ir       <= IM_RDATA;
                        IR_VALID <= 1'b1;
                        IM_REQ   <= 1'b0;
                        BUSY     <= 1'b0;
                        state    <= S_IDLE;
`ifdef FETCH_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        ir        <= '0;
                        IR_VALID  <= 1'b1;
                        IM_REQ    <= 1'b0;
                        BUSY      <= 1'b0;
                        FETCH_ERR <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit
module tb_fetch_unit;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 19;
    localparam int OPC_W   = 5;

    logic                     CLK = 1'b0;
    logic                     EN;
    logic                     LOAD_IR;
    logic                     LOAD_PC;
    logic                     INC_PC;
    logic [ADDR_W-1:0]        BR_ADDR;
    logic                     IM_REQ;
    logic [ADDR_W-1:0]        IM_ADDR;
    logic                     IM_ACK;
    logic [INSTR_W-1:0]       IM_RDATA;
    logic [OPC_W-1:0]         OPCODE;
    logic [INSTR_W-OPC_W-1:0] OPERANDS;
    logic [ADDR_W-1:0]        PC;
    logic                     IR_VALID;
    logic                     BUSY;
    logic                     FETCH_ERR;

    int n_cmp = 0;
    int n_err = 0;
    logic [INSTR_W-1:0] sb_q[$];

    fetch_unit #(
        .ADDR_W(ADDR_W),
        .INSTR_W(INSTR_W),
        .OPC_W(OPC_W),
        .RESET_PC(16'h0000),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK(CLK),
        .EN(EN),
        .LOAD_IR(LOAD_IR),
        .LOAD_PC(LOAD_PC),
        .INC_PC(INC_PC),
        .BR_ADDR(BR_ADDR),
        .IM_REQ(IM_REQ),
        .IM_ADDR(IM_ADDR),
        .IM_ACK(IM_ACK),
        .IM_RDATA(IM_RDATA),
        .OPCODE(OPCODE),
        .OPERANDS(OPERANDS),
        .PC(PC),
        .IR_VALID(IR_VALID),
        .BUSY(BUSY),
        .FETCH_ERR(FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag);
        logic [INSTR_W-1:0] exp;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check({tag, "_ir_valid"}, 32'(IR_VALID), 32'd1);
            check({tag, "_opcode"}, 32'(OPCODE), 32'(exp[INSTR_W-1 -: OPC_W]));
            check({tag, "_operands"}, 32'(OPERANDS), 32'(exp[INSTR_W-OPC_W-1:0]));
        end
    endtask

    initial begin
        EN = 1'b0; LOAD_IR = 1'b0; LOAD_PC = 1'b0; INC_PC = 1'b0;
        BR_ADDR = '0; IM_ACK = 1'b0; IM_RDATA = '0;

        // Reset for two edges
        tick(); tick();
        check("rst_pc", 32'(PC), 32'h0);
        check("rst_ir_valid", 32'(IR_VALID), 32'h0);
        check("rst_im_req", 32'(IM_REQ), 32'h0);
        check("rst_busy", 32'(BUSY), 32'h0);
        check("rst_fetch_err", 32'(FETCH_ERR), 32'h0);

        // Fetch with ack in the first request cycle
        EN = 1'b1; LOAD_IR = 1'b1;
        tick();
        LOAD_IR = 1'b0;
        check("f1_im_req", 32'(IM_REQ), 32'h1);
        check("f1_im_addr", 32'(IM_ADDR), 32'h0);
        check("f1_busy", 32'(BUSY), 32'h1);
        check("f1_ir_valid_low", 32'(IR_VALID), 32'h0);
        IM_ACK = 1'b1; IM_RDATA = 19'h5_A3C1;
        sb_q.push_back(19'h5_A3C1);
        tick();
        IM_ACK = 1'b0;
        check("f1_opcode_const", 32'(OPCODE), 32'h16);
        check("f1_operands_const", 32'(OPERANDS), 32'h23C1);
        check("f1_im_req_drop", 32'(IM_REQ), 32'h0);
        check("f1_busy_drop", 32'(BUSY), 32'h0);
        sb_pop("f1");

        // Delayed ack with PC activity and a redundant LOAD_IR during WAIT
        INC_PC = 1'b1;
        tick();
        INC_PC = 1'b0;
        check("f2_pc_inc", 32'(PC), 32'h1);
        LOAD_IR = 1'b1;
        tick();
        LOAD_IR = 1'b0;
        check("f2_addr_c1", 32'(IM_ADDR), 32'h1);
        LOAD_PC = 1'b1; BR_ADDR = 16'h0040; INC_PC = 1'b1;
        tick();
        LOAD_PC = 1'b0; INC_PC = 1'b0;
        check("f2_pc_branch", 32'(PC), 32'h0040);
        check("f2_addr_c2", 32'(IM_ADDR), 32'h1);
        LOAD_IR = 1'b1;
        tick();
        LOAD_IR = 1'b0;
        check("f2_busy_c3", 32'(BUSY), 32'h1);
        check("f2_addr_c3", 32'(IM_ADDR), 32'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("f2_addr_hold", 32'(IM_ADDR), 32'h1);
            check("f2_req_hold", 32'(IM_REQ), 32'h1);
        end
        IM_ACK = 1'b1; IM_RDATA = 19'h1_2345;
        sb_q.push_back(19'h1_2345);
        tick();
        IM_ACK = 1'b0;
        sb_pop("f2");
        check("f2_pc_after", 32'(PC), 32'h0040);
        tick();
        check("f2_no_queue_req", 32'(IM_REQ), 32'h0);
        check("f2_no_queue_busy", 32'(BUSY), 32'h0);
        IM_ACK = 1'b1; IM_RDATA = 19'h7_FFFF;
        tick();
        IM_ACK = 1'b0;
        check("idle_ack_ir", 32'({OPCODE, OPERANDS}), 32'h1_2345);
        check("idle_ack_valid", 32'(IR_VALID), 32'h1);

        // PC wrap and LOAD_PC priority
        LOAD_PC = 1'b1; BR_ADDR = 16'hFFFF;
        tick();
        check("pc_load_ffff", 32'(PC), 32'hFFFF);
        LOAD_PC = 1'b0; INC_PC = 1'b1;
        tick();
        check("pc_wrap", 32'(PC), 32'h0000);
        LOAD_PC = 1'b1; BR_ADDR = 16'h1234; INC_PC = 1'b1;
        tick();
        LOAD_PC = 1'b0; INC_PC = 1'b0;
        check("pc_priority", 32'(PC), 32'h1234);

        // Same-cycle LOAD_IR + LOAD_PC fetches the old PC
        LOAD_IR = 1'b1; LOAD_PC = 1'b1; BR_ADDR = 16'h0777;
        tick();
        LOAD_IR = 1'b0; LOAD_PC = 1'b0;
        check("same_cyc_addr", 32'(IM_ADDR), 32'h1234);
        check("same_cyc_pc", 32'(PC), 32'h0777);
        check("same_cyc_valid", 32'(IR_VALID), 32'h0);

        // Reset mid-WAIT followed by a stale ack
        EN = 1'b0;
        tick();
        EN = 1'b1; IM_ACK = 1'b1; IM_RDATA = 19'h7_FFFF;
        tick();
        IM_ACK = 1'b0;
        check("midrst_im_req", 32'(IM_REQ), 32'h0);
        check("midrst_busy", 32'(BUSY), 32'h0);
        check("midrst_ir_valid", 32'(IR_VALID), 32'h0);
        check("midrst_ir", 32'({OPCODE, OPERANDS}), 32'h0);
        check("midrst_pc", 32'(PC), 32'h0);

        // Unacknowledged fetch
        LOAD_IR = 1'b1;
        tick();
        LOAD_IR = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_busy_wait", 32'(BUSY), 32'h1);
        end
        sb_q.push_back('0);
        tick();
        check("to_fetch_err", 32'(FETCH_ERR), 32'h1);
        check("to_busy_drop", 32'(BUSY), 32'h0);
        check("to_req_drop", 32'(IM_REQ), 32'h0);
        sb_pop("to");
        LOAD_IR = 1'b1;
        tick();
        LOAD_IR = 1'b0;
        IM_ACK = 1'b1; IM_RDATA = 19'h0_0ABC;
        sb_q.push_back(19'h0_0ABC);
        tick();
        IM_ACK = 1'b0;
        sb_pop("to_next");
        check("to_err_sticky", 32'(FETCH_ERR), 32'h1);
        EN = 1'b0;
        tick();
        EN = 1'b1;
        check("to_err_cleared", 32'(FETCH_ERR), 32'h0);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check("nto_busy_wait", 32'(BUSY), 32'h1);
            check("nto_fetch_err", 32'(FETCH_ERR), 32'h0);
        end
        IM_ACK = 1'b1; IM_RDATA = 19'h0_0ABC;
        sb_q.push_back(19'h0_0ABC);
        tick();
        IM_ACK = 1'b0;
        sb_pop("nto");
        check("nto_busy_drop", 32'(BUSY), 32'h0);
`endif

        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
